trace_uart_wrapper: RTL and testbench
=====================================

TRACE_UART_WRAPPER -- requirements
Module: trace_uart_wrapper

Interface
REQ-001 SHALL have parameter CLK_DIV, default 868, clock cycles per UART bit (legal 2..65535).
REQ-002 SHALL have parameter DEPTH, default 16, trace FIFO records (power of 2, 2..256).
REQ-003 SHALL have parameter MODE, default 0; 0 = trace writes only, 1 = trace writes and reads.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports F_addr, F_instr, M_addr, M_WData, M_RData  input  32 each  CPU fetch/memory bus taps.
REQ-007 SHALL have ports M_WE, M_RE  input  1 each  memory write/read strobes.
REQ-008 SHALL have ports user_F_addr, user_F_instr, user_M_addr, user_M_WData, user_M_RData  output  32 each, and user_M_WE, user_M_RE  output  1 each  bus pass-through.
REQ-009 SHALL have port TxD  output  1  UART serial out, 8N1.
REQ-010 SHALL have port txd_buffer  output  8  byte currently loaded in the transmitter.
REQ-011 SHALL have port overflow  output  1  sticky dropped-record flag.
REQ-012 SHALL have port fifo_level  output  $clog2(DEPTH)+1  records held.

Function
REQ-013 SHALL drive every user_* output combinationally equal to its same-named input, zero latency, unaffected by reset.
REQ-014 SHALL detect a capture event at a rising edge when M_WE=1, or when MODE=1 and M_RE=1.
REQ-015 SHALL, on M_WE=1 and M_RE=1 together, capture one write record only.
REQ-016 SHALL form a record {tag[7:0], M_addr[31:0], data[31:0]}: write tag 0x57 with M_WData; read tag 0x52 with M_RData.
REQ-017 SHALL push the record into the FIFO on the event edge; fifo_level increments on the following cycle.
REQ-018 SHALL drop the record and set overflow=1 when the FIFO is full (level=DEPTH) and no pop occurs that edge.
REQ-019 SHALL accept the push without overflow when full and a pop occurs on the same edge; level stays DEPTH.
REQ-020 SHALL hold overflow at 1 until reset.
REQ-021 SHALL implement transmitter states IDLE, START, DATA, STOP.
REQ-022 SHALL, in IDLE with level>0, pop the head record, load byte 0 (tag) into txd_buffer and go to START next cycle.
REQ-023 SHALL drive TxD=0 in START, data bits LSB first in DATA, and TxD=1 in STOP and IDLE.
REQ-024 SHALL hold each bit exactly CLK_DIV cycles, using a bit-period counter and a 3-bit bit index.
REQ-025 SHALL send record bytes in order: tag, addr[31:24], addr[23:16], addr[15:8], addr[7:0], data[31:24] .. data[7:0] (9 bytes).
REQ-026 SHALL, after STOP of bytes 0-7, load the next byte into txd_buffer and enter START with no idle gap.
REQ-027 SHALL, after STOP of byte 8, return to IDLE for at least one cycle before the next pop.
REQ-028 SHALL take 90*CLK_DIV cycles per record from START of byte 0 to end of STOP of byte 8.
REQ-029 SHALL keep FIFO read/write pointers modulo DEPTH, with wrap-around preserving FIFO order.

Reset
REQ-030 SHALL, on reset=1 at a rising edge: TxD=1, txd_buffer=0x00, overflow=0, fifo_level=0, state IDLE, pointers and counters 0.
REQ-031 SHALL abort an in-flight byte on reset, with TxD=1 from the next cycle, and discard all FIFO contents.
REQ-032 SHALL ignore capture events on an edge where reset=1.

Verification
REQ-033 SHALL cover: CLK_DIV=4, MODE=0, one write M_addr=0x00001004, M_WData=0xDEADBEEF -> TxD bytes 57 00 00 10 04 DE AD BE EF in 360 cycles, then TxD=1.
REQ-034 SHALL cover: MODE=0, M_RE=1 only -> no record and fifo_level=0; MODE=1, same stimulus with M_RData=0x12345678 -> record tag 0x52, data 12 34 56 78.
REQ-035 SHALL cover: DEPTH=4, 6 back-to-back writes while transmitting -> 1 popped plus 4 queued, 1 dropped, overflow=1 sticky, 5 records emitted in order.
REQ-036 SHALL cover: write and read asserted together with MODE=1 -> exactly one record with tag 0x57.
REQ-037 SHALL cover: reset asserted mid-byte 3 -> TxD=1 next cycle, txd_buffer=0x00, fifo_level=0, and a subsequent write is transmitted cleanly.
REQ-038 SHALL cover: 2*DEPTH+1 writes spaced 400 cycles apart -> pointers wrap, all records emitted in order, overflow=0.

Source files
------------

// File: rtl/trace_uart_wrapper.sv
// CPU bus tap that captures memory write (and optionally read) transactions into a small FIFO
// and streams each 9-byte record out over an 8N1 UART.
module trace_uart_wrapper #(
    parameter int unsigned CLK_DIV = 868,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned MODE    = 0
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [31:0]              F_addr,
    input  logic [31:0]              F_instr,
    input  logic [31:0]              M_addr,
    input  logic [31:0]              M_WData,
    input  logic [31:0]              M_RData,
    input  logic                     M_WE,
    input  logic                     M_RE,

    output logic [31:0]              user_F_addr,
    output logic [31:0]              user_F_instr,
    output logic [31:0]              user_M_addr,
    output logic [31:0]              user_M_WData,
    output logic [31:0]              user_M_RData,
    output logic                     user_M_WE,
    output logic                     user_M_RE,

    output logic                     TxD,
    output logic [7:0]               txd_buffer,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned REC_W = 72;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [7:0]       TAG_WRITE = 8'h57;
    localparam logic [7:0]       TAG_READ  = 8'h52;
    localparam logic [3:0]       LAST_BYTE = 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Bus pass-through
    assign user_F_addr  = F_addr;
    assign user_F_instr = F_instr;
    assign user_M_addr  = M_addr;
    assign user_M_WData = M_WData;
    assign user_M_RData = M_RData;
    assign user_M_WE    = M_WE;
    assign user_M_RE    = M_RE;

    // Capture and FIFO
    logic [REC_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] count_q;
    logic             overflow_q;

    logic             read_event;
    logic             capture;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic [REC_W-1:0] rec_in;
    logic [REC_W-1:0] head;

    tx_state_e        state_q;

    // A simultaneous write and read yields a single write record.
    assign read_event = (MODE == 32'd1) && M_RE && !M_WE;
    assign capture    = !reset && (M_WE || read_event);
    assign rec_in     = M_WE ? {TAG_WRITE, M_addr, M_WData} : {TAG_READ, M_addr, M_RData};
    assign full       = (count_q == LVL_FULL);
    assign pop        = (state_q == StIdle) && (count_q != '0);
    assign push_ok    = capture && (!full || pop);
    assign head       = fifo_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= rec_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count_q <= count_q + LVL_W'(1);
            end else if (pop && !push_ok) begin
                count_q <= count_q - LVL_W'(1);
            end
            if (capture && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign overflow   = overflow_q;
    assign fifo_level = count_q;

    // UART transmitter
    logic [CNT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [3:0]       byte_idx_q;
    logic [63:0]      shift_q;
    logic [7:0]       buf_q;
    logic             txd_q;
    logic             bit_end;

    assign bit_end = (bit_cnt_q == BIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            txd_q      <= 1'b1;
            buf_q      <= 8'h00;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        // Tag goes out first; the remaining 8 bytes wait in shift_q, MSB first.
                        buf_q      <= head[71:64];
                        shift_q    <= head[63:0];
                        byte_idx_q <= '0;
                        bit_cnt_q  <= '0;
                        txd_q      <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= buf_q[0];
                        state_q   <= StData;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= buf_q[bit_idx_q + 3'd1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (byte_idx_q == LAST_BYTE) begin
                            state_q <= StIdle;
                        end else begin
                            byte_idx_q <= byte_idx_q + 4'd1;
                            buf_q      <= shift_q[63:56];
                            shift_q    <= {shift_q[55:0], 8'h00};
                            txd_q      <= 1'b0;
                            state_q    <= StStart;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign TxD        = txd_q;
    assign txd_buffer = buf_q;

endmodule

// File: tb/tb_trace_uart_wrapper.sv
// Bench for trace_uart_wrapper: two instances (write-only and write+read tracing) share one bus;
// a UART receiver decodes each TxD stream and compares bytes against a record-level model.
module tb_trace_uart_wrapper;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int REC_CYC = 90 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] F_addr = '0, F_instr = '0, M_addr = '0, M_WData = '0, M_RData = '0;
    logic        M_WE = 1'b0, M_RE = 1'b0;

    logic [31:0] u0_fa, u0_fi, u0_ma, u0_mw, u0_mr, u1_fa, u1_fi, u1_ma, u1_mw, u1_mr;
    logic        u0_we, u0_re, u1_we, u1_re;
    logic        txd0, txd1, ovf0, ovf1;
    logic [7:0]  buf0, buf1;
    logic [$clog2(DEPTH):0] lvl0, lvl1;

    always #5 clk = ~clk;

    trace_uart_wrapper #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .F_addr(F_addr), .F_instr(F_instr), .M_addr(M_addr), .M_WData(M_WData),
        .M_RData(M_RData), .M_WE(M_WE), .M_RE(M_RE),
        .user_F_addr(u0_fa), .user_F_instr(u0_fi), .user_M_addr(u0_ma), .user_M_WData(u0_mw),
        .user_M_RData(u0_mr), .user_M_WE(u0_we), .user_M_RE(u0_re),
        .TxD(txd0), .txd_buffer(buf0), .overflow(ovf0), .fifo_level(lvl0)
    );

    trace_uart_wrapper #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .F_addr(F_addr), .F_instr(F_instr), .M_addr(M_addr), .M_WData(M_WData),
        .M_RData(M_RData), .M_WE(M_WE), .M_RE(M_RE),
        .user_F_addr(u1_fa), .user_F_instr(u1_fi), .user_M_addr(u1_ma), .user_M_WData(u1_mw),
        .user_M_RData(u1_mr), .user_M_WE(u1_we), .user_M_RE(u1_re),
        .TxD(txd1), .txd_buffer(buf1), .overflow(ovf1), .fifo_level(lvl1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Receiver logs, one set per instance
    logic [7:0] rx0_b [256];
    logic       rx0_s [256];
    int         rx0_t [256];
    int         rx0_n = 0;
    logic [7:0] rx1_b [256];
    logic       rx1_s [256];
    int         rx1_t [256];
    int         rx1_n = 0;

    // Model state
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    int         cons [2] = '{0, 0};

    function automatic logic txd_of(input int which);
        return (which != 0) ? txd1 : txd0;
    endfunction

    function automatic int rx_count(input int which);
        return (which != 0) ? rx1_n : rx0_n;
    endfunction

    function automatic logic [7:0] rx_byte(input int which, input int idx);
        return (which != 0) ? rx1_b[idx] : rx0_b[idx];
    endfunction

    function automatic logic rx_stop(input int which, input int idx);
        return (which != 0) ? rx1_s[idx] : rx0_s[idx];
    endfunction

    function automatic int rx_time(input int which, input int idx);
        return (which != 0) ? rx1_t[idx] : rx0_t[idx];
    endfunction

    function automatic int exp_size(input int which);
        return (which != 0) ? exp1.size() : exp0.size();
    endfunction

    function automatic void push_rec(input int which, input logic [7:0] tag,
                                     input logic [31:0] a, input logic [31:0] d);
        logic [71:0] r;
        r = {tag, a, d};
        for (int i = 0; i < 9; i++) begin
            if (which != 0) exp1.push_back(r[71-8*i -: 8]);
            else            exp0.push_back(r[71-8*i -: 8]);
        end
    endfunction

    // Instance 0 traces writes only; instance 1 also traces reads, write wins when both strobe.
    function automatic void model_event(input logic we, input logic re, input logic [31:0] a,
                                        input logic [31:0] wd, input logic [31:0] rd);
        if (we) begin
            push_rec(0, 8'h57, a, wd);
            push_rec(1, 8'h57, a, wd);
        end else if (re) begin
            push_rec(1, 8'h52, a, rd);
        end
    endfunction

    task automatic rx_frame(input int which, output logic ok, output logic [7:0] b,
                            output logic stp);
        ok = 1'b1;
        b = 8'h00;
        stp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < CLK_DIV; k++) begin
                @(negedge clk);
                if (reset) ok = 1'b0;
            end
            if (i < 8) b[i] = txd_of(which);
            else       stp = txd_of(which);
        end
    endtask

    initial begin : mon0
        logic ok, stp;
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (!reset && txd0 === 1'b0) begin
                t = cyc;
                rx_frame(0, ok, b, stp);
                if (ok && rx0_n < 256) begin
                    rx0_b[rx0_n] = b;
                    rx0_s[rx0_n] = stp;
                    rx0_t[rx0_n] = t;
                    rx0_n = rx0_n + 1;
                end
            end
        end
    end

    initial begin : mon1
        logic ok, stp;
        logic [7:0] b;
        int t;
        forever begin
            @(negedge clk);
            if (!reset && txd1 === 1'b0) begin
                t = cyc;
                rx_frame(1, ok, b, stp);
                if (ok && rx1_n < 256) begin
                    rx1_b[rx1_n] = b;
                    rx1_s[rx1_n] = stp;
                    rx1_t[rx1_n] = t;
                    rx1_n = rx1_n + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_rx(input int which);
        logic [7:0] e;
        while (cons[which] < rx_count(which)) begin
            if (exp_size(which) == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL rx%0d_extra observed=%0h expected=none", which,
                       rx_byte(which, cons[which]));
            end else begin
                e = (which != 0) ? exp1.pop_front() : exp0.pop_front();
                check($sformatf("rx%0d_byte%0d", which, cons[which]),
                      64'(rx_byte(which, cons[which])), 64'(e));
                check($sformatf("rx%0d_stop%0d", which, cons[which]),
                      64'(rx_stop(which, cons[which])), 64'd1);
            end
            cons[which]++;
        end
    endtask

    task automatic wait_drain(input int which, input int budget);
        int target;
        int k;
        target = cons[which] + exp_size(which);
        k = 0;
        while (rx_count(which) < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check($sformatf("drain%0d_reached", which), 64'(rx_count(which) >= target), 64'd1);
        check_rx(which);
    endtask

    task automatic bus_op(input logic we, input logic re, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd);
        M_WE = we;
        M_RE = re;
        M_addr = a;
        M_WData = wd;
        M_RData = rd;
        @(posedge clk);
        #1;
        M_WE = 1'b0;
        M_RE = 1'b0;
    endtask

    initial begin : main
        logic [31:0] a, d, r;
        int base0, base1, op;

        // Reset with strobes active: outputs pass through, captures are ignored.
        F_addr = $urandom;
        F_instr = $urandom;
        M_addr = $urandom;
        M_WData = $urandom;
        M_RData = $urandom;
        M_WE = 1'b1;
        M_RE = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pt_F_addr", 64'(u1_fa), 64'(F_addr));
        check("pt_F_instr", 64'(u1_fi), 64'(F_instr));
        check("pt_M_addr", 64'(u1_ma), 64'(M_addr));
        check("pt_M_WData", 64'(u1_mw), 64'(M_WData));
        check("pt_M_RData", 64'(u1_mr), 64'(M_RData));
        check("pt_M_WE", 64'(u1_we), 64'(M_WE));
        check("pt_M_RE", 64'(u0_re), 64'(M_RE));
        check("rst_txd0", 64'(txd0), 64'd1);
        check("rst_txd1", 64'(txd1), 64'd1);
        check("rst_buf1", 64'(buf1), 64'h00);
        check("rst_ovf1", 64'(ovf1), 64'd0);
        check("rst_lvl0", 64'(lvl0), 64'd0);
        check("rst_lvl1", 64'(lvl1), 64'd0);
        M_WE = 1'b0;
        M_RE = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ignored_lvl1", 64'(lvl1), 64'd0);

        // Single write record with exact framing and duration.
        bus_op(1'b1, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, $urandom);
        model_event(1'b1, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0);
        check("wr_lvl0", 64'(lvl0), 64'd1);
        check("wr_lvl1", 64'(lvl1), 64'd1);
        @(posedge clk);
        #1;
        check("pop_lvl0", 64'(lvl0), 64'd0);
        check("pop_txd0", 64'(txd0), 64'd0);
        check("pop_buf0", 64'(buf0), 64'h57);
        base0 = cons[0];
        wait_drain(0, 2 * REC_CYC);
        wait_drain(1, 2 * REC_CYC);
        for (int k = 1; k < 9; k++) begin
            check($sformatf("byte_spacing%0d", k),
                  64'(rx_time(0, base0 + k) - rx_time(0, base0 + k - 1)), 64'(10 * CLK_DIV));
        end
        repeat (10) @(posedge clk);
        #1;
        check("idle_txd0", 64'(txd0), 64'd1);

        // Read-only strobe: traced only by the MODE=1 instance.
        a = $urandom;
        bus_op(1'b0, 1'b1, a, $urandom, 32'h1234_5678);
        model_event(1'b0, 1'b1, a, 32'h0, 32'h1234_5678);
        check("rd_lvl0", 64'(lvl0), 64'd0);
        check("rd_lvl1", 64'(lvl1), 64'd1);
        @(posedge clk);
        #1;
        check("rd_buf1", 64'(buf1), 64'h52);
        wait_drain(1, 2 * REC_CYC);
        repeat (10) @(posedge clk);
        #1;

        // Write and read together: one write record.
        a = $urandom;
        d = $urandom;
        r = $urandom;
        bus_op(1'b1, 1'b1, a, d, r);
        model_event(1'b1, 1'b1, a, d, r);
        check("wr_rd_lvl1", 64'(lvl1), 64'd1);
        wait_drain(0, 2 * REC_CYC);
        wait_drain(1, 2 * REC_CYC);
        repeat (10) @(posedge clk);
        #1;

        // Six back-to-back writes into a 4-deep FIFO: the sixth is dropped.
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            d = $urandom;
            if (i == 5) check("ovf_before", 64'(ovf1), 64'd0);
            bus_op(1'b1, 1'b0, a, d, 32'h0);
            if (i < 5) model_event(1'b1, 1'b0, a, d, 32'h0);
        end
        check("ovf_set0", 64'(ovf0), 64'd1);
        check("ovf_set1", 64'(ovf1), 64'd1);
        check("ovf_lvl1", 64'(lvl1), 64'(DEPTH));
        wait_drain(0, 6 * REC_CYC);
        wait_drain(1, 6 * REC_CYC);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_sticky", 64'(ovf1), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("ovf_cleared", 64'(ovf1), 64'd0);

        // Reset in the middle of byte 3 with a second record still queued.
        base0 = cons[0];
        base1 = cons[1];
        a = $urandom;
        d = $urandom;
        bus_op(1'b1, 1'b0, a, d, 32'h0);
        model_event(1'b1, 1'b0, a, d, 32'h0);
        a = $urandom;
        d = $urandom;
        bus_op(1'b1, 1'b0, a, d, 32'h0);
        model_event(1'b1, 1'b0, a, d, 32'h0);
        check("mid_lvl1", 64'(lvl1), 64'd1);
        repeat (139) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_txd0", 64'(txd0), 64'd1);
        check("mid_txd1", 64'(txd1), 64'd1);
        check("mid_buf1", 64'(buf1), 64'h00);
        check("mid_lvl1_clr", 64'(lvl1), 64'd0);
        reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("mid_rx0_count", 64'(rx_count(0)), 64'(base0 + 3));
        check("mid_rx1_count", 64'(rx_count(1)), 64'(base1 + 3));
        check_rx(0);
        check_rx(1);
        exp0.delete();
        exp1.delete();
        a = $urandom;
        d = $urandom;
        bus_op(1'b1, 1'b0, a, d, 32'h0);
        model_event(1'b1, 1'b0, a, d, 32'h0);
        wait_drain(0, 2 * REC_CYC);
        wait_drain(1, 2 * REC_CYC);
        repeat (10) @(posedge clk);
        #1;

        // 2*DEPTH+1 spaced random events: pointers wrap, nothing dropped.
        for (int i = 0; i < 2 * DEPTH + 1; i++) begin
            op = $urandom_range(0, 2);
            a = $urandom;
            d = $urandom;
            r = $urandom;
            bus_op(op != 1, op != 0, a, d, r);
            model_event(op != 1, op != 0, a, d, r);
            repeat (399) @(posedge clk);
            #1;
        end
        wait_drain(0, 3 * REC_CYC);
        wait_drain(1, 3 * REC_CYC);
        check("wrap_ovf0", 64'(ovf0), 64'd0);
        check("wrap_ovf1", 64'(ovf1), 64'd0);

        repeat (100) @(posedge clk);
        #1;
        check("final_rx0", 64'(rx_count(0)), 64'(cons[0]));
        check("final_rx1", 64'(rx_count(1)), 64'(cons[1]));
        check("final_lvl1", 64'(lvl1), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
